jhash_mix: RTL and testbench

- Single mixing step of the Jenkins lookup3 hash: x -= z; x ^= rotl(z, s); z += y.
- Instantiated by jhash_core, which feeds back OB→a, OC→b, OA→c each S_RUN cycle, so one primitive covers all six rounds (shifts 4, 6, 8, 16, 19, 4).
- Purely combinational by default; an output register stage can be compiled in.

---
 rtl/jhash_pkg.sv | 14 +
 rtl/jhash_rotl.sv | 20 ++
 rtl/jhash_mix.sv | 51 +++++
 tb/tb_jhash_mix.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jhash_pkg.sv
// Shared constants for the lookup3 hash datapath (jhash_mix, jhash_rotl, jhash_core).
package jhash_pkg;
  localparam int JHASH_W = 32;

  // Rotate amounts for the six mixing rounds, in the order jhash_core applies them.
  localparam logic [4:0] SH_R0 = 5'd4;
  localparam logic [4:0] SH_R1 = 5'd6;
  localparam logic [4:0] SH_R2 = 5'd8;
  localparam logic [4:0] SH_R3 = 5'd16;
  localparam logic [4:0] SH_R4 = 5'd19;
  localparam logic [4:0] SH_R5 = 5'd4;

  localparam logic [JHASH_W-1:0] JHASH_INIT = 32'hDEAD_BEEF;
endpackage

// File: rtl/jhash_rotl.sv
// Barrel left-rotator: stage k rotates by 2**k when shift[k] is set.
module jhash_rotl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shift,
  output logic [WIDTH-1:0] dout
);
  logic [SHW:0][WIDTH-1:0] st;

  assign st[0] = din;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int D = 1 << k;
    assign st[k+1] = shift[k] ? {st[k][WIDTH-1-D:0], st[k][WIDTH-1:WIDTH-D]} : st[k];
  end

  assign dout = st[SHW];
endmodule

// File: rtl/jhash_mix.sv
// One lookup3 mix step: OA = (a - c) ^ rotl(c, shift), OB = b, OC = c + b.
// Define JHASH_MIX_OUTREG_EN to register the outputs (1-cycle latency, async active-low clear).
module jhash_mix
  import jhash_pkg::*;
#(
  parameter int WIDTH = JHASH_W,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [SHW-1:0]   shift,
  output logic [WIDTH-1:0] OA,
  output logic [WIDTH-1:0] OB,
  output logic [WIDTH-1:0] OC
);
  logic [WIDTH-1:0] rot, oa_c, oc_c;

  jhash_rotl #(.WIDTH(WIDTH), .SHW(SHW)) u_rotl (
    .din  (c),
    .shift(shift),
    .dout (rot)
  );

  // Both arithmetic ops wrap modulo 2**WIDTH by width truncation.
  assign oa_c = (a - c) ^ rot;
  assign oc_c = c + b;

`ifdef JHASH_MIX_OUTREG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OA <= '0;
      OB <= '0;
      OC <= '0;
    end else begin
      OA <= oa_c;
      OB <= b;
      OC <= oc_c;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign OA = oa_c;
  assign OB = b;
  assign OC = oc_c;
`endif
endmodule

// File: tb/tb_jhash_mix.sv
// Self-checking bench for jhash_mix: directed table, random sweep vs a lookup3 step model,
// chained six-round sequence, and reset behaviour of the registered build.
module tb_jhash_mix;
  import jhash_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic [4:0]  shift = '0;
  logic [31:0] oa, ob, oc;

  int n_chk  = 0;
  int n_fail = 0;

  jhash_mix #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .shift(shift),
    .OA(oa), .OB(ob), .OC(oc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, c;
    logic [4:0]  s;
    logic [31:0] ea, eb, ec;
  } vec_t;

  // Reference: rotate via a doubled 64-bit word so s = 0 needs no special case.
  function automatic logic [31:0] ref_rotl(logic [31:0] x, int s);
    logic [63:0] d;
    d = {x, x} << s;
    return d[63:32];
  endfunction

  function automatic void ref_mix(input logic [31:0] x, y, z, input int s,
                                  output logic [31:0] ra, rb, rc);
    ra = (x - z) ^ ref_rotl(z, s);
    rb = y;
    rc = z + y;
  endfunction

  task automatic cmp(string name, logic [31:0] ea, eb, ec);
    n_chk++;
    if (oa !== ea || ob !== eb || oc !== ec) begin
      n_fail++;
      $display("FAIL %s: got OA=%h OB=%h OC=%h, want OA=%h OB=%h OC=%h",
               name, oa, ob, oc, ea, eb, ec);
    end
  endtask

  // Drive on the falling edge; sample once the result is due (same cycle or next rising edge).
  task automatic apply(string name, logic [31:0] ia, ib, ic, logic [4:0] is,
                       logic [31:0] ea, eb, ec);
    @(negedge clk);
    a = ia; b = ib; c = ic; shift = is;
`ifdef JHASH_MIX_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    cmp(name, ea, eb, ec);
  endtask

  vec_t tbl[6];

  initial begin
    logic [31:0] ra, rb, rc, x, y, z;
    logic [4:0] shs [6];

    tbl[0] = '{32'h0, 32'h0, 32'h0, 5'd4, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{32'h5, 32'h3, 32'h1, 5'd4, 32'h14, 32'h3, 32'h4};
    tbl[2] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 5'd19, 32'hFFF7_FFFF, 32'hFFFF_FFFF, 32'h0};
    tbl[3] = '{32'h7, 32'h0, 32'h3, 5'd0, 32'h7, 32'h0, 32'h3};
    tbl[4] = '{32'h1, 32'h2, 32'h1, 5'd31, 32'h8000_0000, 32'h2, 32'h3};
    tbl[5] = '{32'h0, 32'h0, 32'h8000_0000, 5'd4, 32'h8000_0008, 32'h0, 32'h8000_0000};

`ifdef JHASH_MIX_OUTREG_EN
    // Held in reset: outputs stay cleared regardless of inputs and clock.
    @(negedge clk);
    a = 32'h5; b = 32'h3; c = 32'h1; shift = 5'd4;
    @(posedge clk); #1;
    cmp("reset_hold", 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("release_no_edge", 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    cmp("first_update", 32'h14, 32'h3, 32'h4);
`else
    // No state: outputs follow inputs even with reset asserted.
    @(negedge clk);
    a = 32'h5; b = 32'h3; c = 32'h1; shift = 5'd4;
    #1;
    cmp("comb_in_reset", 32'h14, 32'h3, 32'h4);
    rst = 1'b1;
`endif

    foreach (tbl[i])
      apply($sformatf("table%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s,
            tbl[i].ea, tbl[i].eb, tbl[i].ec);

    // Random sweep, cycling every shift value.
    for (int i = 0; i < 10000; i++) begin
      x = $urandom; y = $urandom; z = $urandom;
      ref_mix(x, y, z, i % 32, ra, rb, rc);
      apply($sformatf("rand%0d", i), x, y, z, 5'(i % 32), ra, rb, rc);
    end

    // Six chained rounds with jhash_core's feedback (OB->a, OC->b, OA->c).
    shs[0] = SH_R0; shs[1] = SH_R1; shs[2] = SH_R2;
    shs[3] = SH_R3; shs[4] = SH_R4; shs[5] = SH_R5;
    x = JHASH_INIT; y = 32'h0123_4567; z = 32'h89AB_CDEF;
    for (int r = 0; r < 6; r++) begin
      ref_mix(x, y, z, int'(shs[r]), ra, rb, rc);
      apply($sformatf("chain_r%0d", r), x, y, z, shs[r], ra, rb, rc);
      x = rb; y = rc; z = ra;
    end

`ifdef JHASH_MIX_OUTREG_EN
    // Mid-stream reset clears outputs without waiting for a clock edge.
    @(negedge clk);
    a = 32'h5; b = 32'h3; c = 32'h1; shift = 5'd4;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    cmp("async_clear", 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    cmp("clear_held", 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("resume", 32'h14, 32'h3, 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
